// File: rtl/muu_response_merge512_pkg.sv
// muu_response_merge512_pkg
// Shared definitions for the MUU response merge path. The request splitter
// decodes the same fields, so both blocks take them from here.
//   - widths of the meta, key, value and network beat buses
//   - meta_t: field layout of the packed response metadata word
//   - state_t: merge FSM encodings (state[1:0] is exported on _debug)
//   - header beat assembly helpers
package muu_response_merge512_pkg;

    localparam int NET_META_WIDTH = 64;
    localparam int OPS_META_WIDTH = 96;
    localparam int USER_BITS      = 3;
    localparam int VALUE_WIDTH    = 512;
    localparam int KEY_WIDTH      = 64;
    localparam int META_WIDTH     = NET_META_WIDTH + OPS_META_WIDTH + USER_BITS;
    localparam int BEAT_WIDTH     = VALUE_WIDTH + KEY_WIDTH;

    // Header beat field positions
    localparam int HDR_NETMETA_LSB = 512;
    localparam int HDR_LOADLEN_LSB = 32;
    localparam int HDR_OPCODE_LSB  = 24;
    localparam int HDR_PEERID_LSB  = 16;
    localparam int HDR_HDRB_LSB    = 32;
    localparam int HDR_HDRA_LSB    = 0;

    typedef struct packed {
        logic [2:0]  userid;
        logic [3:0]  rsvd;
        logic [3:0]  opc_lo;
        logic [7:0]  opcode;
        logic [15:0] hdr_b;
        logic [31:0] hdr_a;
        logic [7:0]  peerid;
        logic [7:0]  keylen;
        logic [15:0] vallen;
        logic [63:0] net_meta;
    } meta_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_HDR2  = 3'd3,
        ST_KEY   = 3'd4,
        ST_VALUE = 3'd5,
        ST_PAD   = 3'd6,
        ST_DRAIN = 3'd7
    } state_t;

    // Any non-zero keylen means exactly one key beat.
    function automatic logic [15:0] calc_loadlen(input logic [7:0] keylen,
                                                 input logic [15:0] vallen);
        return vallen + {15'd0, (keylen != 8'd0)};
    endfunction

    function automatic logic [BEAT_WIDTH-1:0] hdr0_beat(input logic [63:0] net_meta,
                                                        input logic [15:0] loadlen,
                                                        input logic [7:0]  opcode,
                                                        input logic [7:0]  peerid);
        logic [BEAT_WIDTH-1:0] b;
        b = '0;
        b[HDR_NETMETA_LSB +: 64] = net_meta;
        b[HDR_LOADLEN_LSB +: 16] = loadlen;
        b[HDR_OPCODE_LSB  +: 8]  = opcode;
        b[HDR_PEERID_LSB  +: 8]  = peerid;
        return b;
    endfunction

    function automatic logic [BEAT_WIDTH-1:0] hdr2_beat(input logic [15:0] hdr_b,
                                                        input logic [31:0] hdr_a);
        logic [BEAT_WIDTH-1:0] b;
        b = '0;
        b[HDR_HDRB_LSB +: 16] = hdr_b;
        b[HDR_HDRA_LSB +: 32] = hdr_a;
        return b;
    endfunction

endpackage

// File: rtl/muu_response_merge512_outreg.sv
// muu_axis_outreg576
// One-deep AXI-Stream output register. Takes a new beat whenever the register
// is empty or its current beat is being consumed, so it sustains one beat per
// cycle and holds every output steady while stalled.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_user   beat offered by the producer
//   in_ready                 register can take a beat this cycle
//   m_axis_*                 registered stream towards the network TX path
module muu_axis_outreg576
    import muu_response_merge512_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [BEAT_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic [USER_BITS-1:0]  in_user,
    output logic                  in_ready,
    output logic [BEAT_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_BITS-1:0]  m_axis_tuserid,
    input  logic                  m_axis_tready
);

    assign in_ready = !m_axis_tvalid || m_axis_tready;

    // Payload only moves when a beat is actually loaded, so a drained register
    // keeps its last contents with tvalid low.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid  <= 1'b0;
            m_axis_tlast   <= 1'b0;
            m_axis_tdata   <= '0;
            m_axis_tuserid <= '0;
        end else if (in_ready) begin
            m_axis_tvalid <= in_valid;
            if (in_valid) begin
                m_axis_tdata   <= in_data;
                m_axis_tlast   <= in_last;
                m_axis_tuserid <= in_user;
            end
        end
    end

endmodule

// File: rtl/muu_response_merge512.sv
// muu_response_merge512
// Merges a response meta word, an optional 64-bit key and a 512-bit value
// stream into one 576-bit network packet: HDR0, HDR1, HDR2, [KEY], VALUE...
// A value stream shorter than the header length is padded with zero beats;
// a longer one is drained and discarded.
// Ports:
//   clk, rst                             clock, synchronous active-high reset
//   meta_data/meta_valid/meta_ready      response metadata handshake
//   key_data/key_valid/key_last/key_ready    key word handshake
//   value_data/value_valid/value_last/value_ready  value stream handshake
//   m_axis_*                             packet stream to the network
//   _debug                               [3:2] state[1:0], [1:0]=3 on a
//                                        length-mismatch cycle
module muu_response_merge512
    import muu_response_merge512_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [META_WIDTH-1:0]  meta_data,
    input  logic                   meta_valid,
    output logic                   meta_ready,
    input  logic [KEY_WIDTH-1:0]   key_data,
    input  logic                   key_valid,
    input  logic                   key_last,
    output logic                   key_ready,
    input  logic [VALUE_WIDTH-1:0] value_data,
    input  logic                   value_valid,
    input  logic                   value_last,
    output logic                   value_ready,
    output logic [BEAT_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    output logic [USER_BITS-1:0]   m_axis_tuserid,
    input  logic                   m_axis_tready,
    output logic [3:0]             _debug
);

    state_t                state;
    meta_t                 meta_q;
    logic [15:0]           valleft;
    logic                  dbg_flag;
    logic                  out_free;
    logic                  beat_valid;
    logic [BEAT_WIDTH-1:0] beat_data;
    logic                  beat_last;
    logic                  has_key;
    logic [15:0]           loadlen;
    logic [2:0]            state_bits;
    logic                  unused_bits;

    assign has_key    = (meta_q.keylen != 8'd0);
    assign loadlen    = calc_loadlen(meta_q.keylen, meta_q.vallen);
    assign state_bits = 3'(state);
    assign _debug     = {state_bits[1:0], dbg_flag, dbg_flag};

    // The key is always a single beat, so key_last carries no information.
    assign unused_bits = ^{key_last, meta_q.rsvd, meta_q.opc_lo, state_bits[2]};

    // DRAIN discards beats, so it does not need room in the output register.
    assign meta_ready  = !rst && (state == ST_IDLE) && meta_valid;
    assign key_ready   = !rst && (state == ST_KEY) && out_free;
    assign value_ready = !rst && (((state == ST_VALUE) && out_free) || (state == ST_DRAIN));

    // Beat offered to the output register in the current state.
    always_comb begin
        beat_valid = 1'b0;
        beat_data  = '0;
        beat_last  = 1'b0;
        case (state)
            ST_HDR0: begin
                beat_valid = 1'b1;
                beat_data  = hdr0_beat(meta_q.net_meta, loadlen, meta_q.opcode, meta_q.peerid);
            end
            ST_HDR1: beat_valid = 1'b1;
            ST_HDR2: begin
                beat_valid = 1'b1;
                beat_data  = hdr2_beat(meta_q.hdr_b, meta_q.hdr_a);
                beat_last  = (loadlen == 16'd0);
            end
            ST_KEY: begin
                beat_valid = key_valid;
                beat_data  = {{VALUE_WIDTH{1'b0}}, key_data};
                beat_last  = (meta_q.vallen == 16'd0);
            end
            ST_VALUE: begin
                beat_valid = value_valid;
                beat_data  = {{KEY_WIDTH{1'b0}}, value_data};
                beat_last  = (valleft == 16'd0);
            end
            ST_PAD: begin
                beat_valid = 1'b1;
                beat_last  = (valleft == 16'd0);
            end
            default: ;
        endcase
    end

    // valleft counts the value (or pad) beats still owed after the current
    // one. An early value_last switches to PAD with the remainder; a missing
    // value_last after the final beat switches to DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            meta_q   <= '0;
            valleft  <= '0;
            dbg_flag <= 1'b0;
        end else begin
            dbg_flag <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (meta_ready) begin
                        meta_q <= meta_t'(meta_data);
                        state  <= ST_HDR0;
                    end
                end
                ST_HDR0: if (out_free) state <= ST_HDR1;
                ST_HDR1: if (out_free) state <= ST_HDR2;
                ST_HDR2: begin
                    if (out_free) begin
                        if (loadlen == 16'd0) begin
                            state <= ST_IDLE;
                        end else if (has_key) begin
                            state <= ST_KEY;
                        end else begin
                            state   <= ST_VALUE;
                            valleft <= meta_q.vallen - 16'd1;
                        end
                    end
                end
                ST_KEY: begin
                    if (key_valid && key_ready) begin
                        if (meta_q.vallen == 16'd0) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_VALUE;
                            valleft <= meta_q.vallen - 16'd1;
                        end
                    end
                end
                ST_VALUE: begin
                    if (value_valid && value_ready) begin
                        if (valleft == 16'd0) begin
                            state    <= value_last ? ST_IDLE : ST_DRAIN;
                            dbg_flag <= !value_last;
                        end else if (value_last) begin
                            state    <= ST_PAD;
                            valleft  <= valleft - 16'd1;
                            dbg_flag <= 1'b1;
                        end else begin
                            valleft <= valleft - 16'd1;
                        end
                    end
                end
                ST_PAD: begin
                    if (out_free) begin
                        if (valleft == 16'd0) state <= ST_IDLE;
                        else                  valleft <= valleft - 16'd1;
                    end
                end
                ST_DRAIN: begin
                    if (value_valid && value_ready && value_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    muu_axis_outreg576 u_outreg (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (beat_valid),
        .in_data        (beat_data),
        .in_last        (beat_last),
        .in_user        (meta_q.userid),
        .in_ready       (out_free),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuserid (m_axis_tuserid),
        .m_axis_tready  (m_axis_tready)
    );

endmodule

// File: tb/tb_muu_response_merge512.sv
// tb_muu_response_merge512
// Directed and randomized-backpressure bench for muu_response_merge512.
// Beats are collected at the falling edge and compared against a packet
// model built from the meta word, key and value stream offered upstream.
module tb_muu_response_merge512;

    logic         clk = 1'b0;
    logic         rst;
    logic [162:0] meta_data;
    logic         meta_valid, meta_ready;
    logic [63:0]  key_data;
    logic         key_valid, key_last, key_ready;
    logic [511:0] value_data;
    logic         value_valid, value_last, value_ready;
    logic [575:0] m_axis_tdata;
    logic         m_axis_tvalid, m_axis_tlast;
    logic [2:0]   m_axis_tuserid;
    logic         m_axis_tready = 1'b1;
    logic [3:0]   dbg;

    int           tests_run = 0;
    int           tests_failed = 0;
    logic [579:0] got[$];
    logic [579:0] exp_q[$];
    logic [511:0] vals[8];
    int           dbg_pulses = 0;
    logic         kv_ready_seen = 1'b0;
    logic         bp_en = 1'b0;
    logic         prev_stall = 1'b0;
    logic [579:0] prev_out;

    always #5 clk = ~clk;

    muu_response_merge512 dut (
        .clk            (clk),
        .rst            (rst),
        .meta_data      (meta_data),
        .meta_valid     (meta_valid),
        .meta_ready     (meta_ready),
        .key_data       (key_data),
        .key_valid      (key_valid),
        .key_last       (key_last),
        .key_ready      (key_ready),
        .value_data     (value_data),
        .value_valid    (value_valid),
        .value_last     (value_last),
        .value_ready    (value_ready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuserid (m_axis_tuserid),
        .m_axis_tready  (m_axis_tready),
        ._debug         (dbg)
    );

    task automatic check_output(input string tag, input logic [579:0] obs, input logic [579:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Downstream ready: always high, or ~30% low when backpressure is on.
    always @(posedge clk) begin
        #1;
        m_axis_tready = bp_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end

    // Beat collector, stall-stability checker and sideband observers.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check_output("stall_stable", {m_axis_tlast, m_axis_tuserid, m_axis_tdata}, prev_out);
            if (m_axis_tvalid && m_axis_tready)
                got.push_back({m_axis_tlast, m_axis_tuserid, m_axis_tdata});
            if (dbg[1:0] == 2'b11) dbg_pulses++;
            if (key_ready || value_ready) kv_ready_seen = 1'b1;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_out   = {m_axis_tlast, m_axis_tuserid, m_axis_tdata};
        end
    end

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [162:0] mk_meta(input logic [2:0] uid, input logic [7:0] keylen,
                                             input logic [15:0] vallen, input logic [31:0] salt);
        return {uid, 4'hF, 4'hA, salt[7:0], salt[31:16], salt ^ 32'h1234_5678, salt[15:8],
                keylen, vallen, salt, ~salt};
    endfunction

    // Expected packet: 3 headers, then (unless loadlen is 0) an optional key
    // beat and exactly vallen value slots, zero-filled past the offered stream.
    function automatic void model_packet(input logic [162:0] m, input logic [63:0] key, input int nvals);
        logic [15:0]  vallen;
        logic         has_key;
        logic [15:0]  loadlen;
        logic [2:0]   uid;
        logic [575:0] b;
        logic [579:0] t;
        vallen  = m[79:64];
        has_key = (m[87:80] != 8'd0);
        loadlen = vallen + 16'(has_key);
        uid     = m[162:160];
        b = '0;
        b[575:512] = m[63:0];
        b[47:32]   = loadlen;
        b[31:24]   = m[151:144];
        b[23:16]   = m[95:88];
        exp_q.push_back({1'b0, uid, b});
        exp_q.push_back({1'b0, uid, 576'd0});
        b = '0;
        b[47:32] = m[143:128];
        b[31:0]  = m[127:96];
        exp_q.push_back({1'b0, uid, b});
        if (loadlen != 16'd0) begin
            if (has_key) exp_q.push_back({1'b0, uid, 512'd0, key});
            for (int i = 0; i < int'(vallen); i++)
                exp_q.push_back({1'b0, uid, (i < nvals) ? {64'd0, vals[i]} : 576'd0});
        end
        t = exp_q.pop_back();
        t[579] = 1'b1;
        exp_q.push_back(t);
    endfunction

    task automatic send_meta(input logic [162:0] m);
        int n = 0;
        meta_data  = m;
        meta_valid = 1'b1;
        @(negedge clk);
        while (!meta_ready && n < 200) begin @(negedge clk); n++; end
        check_output("meta_wait", 580'(n < 200), 580'(1));
        @(posedge clk); #1;
        meta_valid = 1'b0;
    endtask

    // ch 0 = key channel, ch 1 = value channel.
    task automatic apply_stimulus(input int ch, input logic [511:0] d, input logic last);
        int n = 0;
        if (ch == 0) begin
            key_data = d[63:0]; key_last = last; key_valid = 1'b1;
        end else begin
            value_data = d; value_last = last; value_valid = 1'b1;
        end
        @(negedge clk);
        while (!((ch == 0) ? key_ready : value_ready) && n < 200) begin @(negedge clk); n++; end
        check_output((ch == 0) ? "key_wait" : "value_wait", 580'(n < 200), 580'(1));
        @(posedge clk); #1;
        key_valid   = 1'b0;
        value_valid = 1'b0;
    endtask

    task automatic run_packet(input string tag, input logic [162:0] m, input logic [63:0] key, input int nvals);
        int n = 0;
        got.delete();
        exp_q.delete();
        model_packet(m, key, nvals);
        send_meta(m);
        if (m[87:80] != 8'd0) apply_stimulus(0, {448'd0, key}, 1'b1);
        if (m[79:64] != 16'd0)
            for (int i = 0; i < nvals; i++) apply_stimulus(1, vals[i], i == nvals - 1);
        while (got.size() < exp_q.size() && n < 400) begin @(negedge clk); n++; end
        check_output({tag, "_done"}, 580'(n < 400), 580'(1));
        repeat (4) @(negedge clk);
        check_output({tag, "_count"}, 580'(got.size()), 580'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check_output($sformatf("%s_beat%0d", tag, i), got[i], exp_q[i]);
        check_output({tag, "_idle_debug"}, 580'(dbg), 580'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [162:0] m;
        logic [5:0]   lasts;
        int           kl, vl, nv;

        rst = 1'b1;
        meta_valid = 1'b0; meta_data = '0;
        key_valid = 1'b0; key_data = '0; key_last = 1'b0;
        value_valid = 1'b0; value_data = '0; value_last = 1'b0;
        for (int i = 0; i < 8; i++) vals[i] = rand512();
        repeat (3) @(posedge clk); #1;

        // Reset state
        check_output("rst_tdata", 580'(m_axis_tdata), 580'(0));
        check_output("rst_ctrl", 580'({m_axis_tvalid, m_axis_tlast, m_axis_tuserid,
                                       meta_ready, key_ready, value_ready, dbg}), 580'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // keylen=1, vallen=2, key 0xA5: six beats, tlast only on the last
        m = mk_meta(3'd5, 8'd1, 16'd2, 32'hC0DE_0001);
        run_packet("t1", m, 64'hA5, 2);
        check_output("t1_loadlen", 580'(got[0][47:32]), 580'(16'd3));
        check_output("t1_netmeta", 580'(got[0][575:512]), 580'({32'hC0DE_0001, 32'h3F21_FFFE}));
        check_output("t1_hdr1", 580'(got[1][575:0]), 580'(0));
        check_output("t1_key", 580'(got[3][575:0]), 580'(64'hA5));
        check_output("t1_user", 580'(got[0][578:576]), 580'(3'd5));
        for (int i = 0; i < 6; i++) lasts[i] = got[i][579];
        check_output("t1_tlast_pattern", 580'(lasts), 580'(6'b100000));

        // keylen=0, vallen=0: header only, key/value ready never raised
        kv_ready_seen = 1'b0;
        run_packet("t2", mk_meta(3'd2, 8'd0, 16'd0, 32'h0000_BEEF), 64'h0, 0);
        check_output("t2_hdr2_tlast", 580'(got[2][579]), 580'(1));
        check_output("t2_no_kv_ready", 580'(kv_ready_seen), 580'(0));

        // vallen=3, value_last on 2nd beat: one zero PAD beat closes the packet
        dbg_pulses = 0;
        run_packet("t3", mk_meta(3'd1, 8'd0, 16'd3, 32'h5555_0003), 64'h0, 2);
        check_output("t3_pad_beat", got[5], {1'b1, 3'd1, 576'd0});
        check_output("t3_debug_pulses", 580'(dbg_pulses), 580'(1));

        // vallen=1 with a 3-beat value stream: 1 value beat, 2 drained
        dbg_pulses = 0;
        run_packet("t4", mk_meta(3'd6, 8'd0, 16'd1, 32'hAAAA_0004), 64'h0, 3);
        check_output("t4_value_beat", got[3], {1'b1, 3'd6, 64'd0, vals[0]});
        check_output("t4_debug_pulses", 580'(dbg_pulses), 580'(1));
        run_packet("t4_next", mk_meta(3'd7, 8'd1, 16'd2, 32'h0BAD_0005), 64'h1234, 2);

        // 100 packets with random backpressure, lengths and short/long streams
        bp_en = 1'b1;
        for (int p = 0; p < 100; p++) begin
            for (int i = 0; i < 8; i++) vals[i] = rand512();
            kl = $urandom_range(0, 3);
            vl = $urandom_range(0, 6);
            if (vl == 0)                        nv = 0;
            else if ($urandom_range(0, 3) == 0) nv = $urandom_range(1, 7);
            else                                nv = vl;
            m = mk_meta(3'($urandom_range(0, 7)), 8'(kl), 16'(vl), $urandom);
            run_packet($sformatf("rnd%0d", p), m, {$urandom, $urandom}, nv);
        end
        bp_en = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of VALUE, then a clean packet
        got.delete();
        send_meta(mk_meta(3'd4, 8'd0, 16'd4, 32'h7777_0006));
        apply_stimulus(1, vals[0], 1'b0);
        apply_stimulus(1, vals[1], 1'b0);
        check_output("t6_in_value", 580'(dbg[3:2]), 580'(2'b01));
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("t6_rst_outputs", 580'({m_axis_tvalid, meta_ready, key_ready, value_ready}), 580'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check_output("t6_after_rst", 580'({m_axis_tvalid, meta_ready, key_ready, value_ready, dbg}), 580'(0));
        run_packet("t6_clean", mk_meta(3'd4, 8'd1, 16'd1, 32'h1357_0007), 64'hBEEF, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
